// File: rtl/scr1_dmi_arb_pkg.sv
// Shared definitions for the DMI arbiter.
// Contents: DMI address/data widths, the number of arbitrated ports,
// the default timeout length, the arbiter FSM state type, and a helper
// that turns a port index into a one-hot port vector.
package scr1_dmi_arb_pkg;

  localparam int SCR1_DBG_DMI_ADDR_WIDTH  = 7;
  localparam int SCR1_DBG_DMI_DATA_WIDTH  = 32;
  localparam int SCR1_DBG_DMI_ARB_PORTS   = 2;
  localparam int SCR1_DBG_DMI_ARB_TMO_CYC = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } type_scr1_dmi_arb_fsm_e;

  function automatic logic [SCR1_DBG_DMI_ARB_PORTS-1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/scr1_dmi_arb_rr.sv
// Two-way round-robin grant.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (pointer -> port 0)
//   req_i     - request vector
//   upd_i     - advance the pointer past the current grant
//   gnt_o     - one-hot grant (combinational), 0 when no request
module scr1_dmi_arb_rr
  import scr1_dmi_arb_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic [SCR1_DBG_DMI_ARB_PORTS-1:0] req_i,
  input  logic                              upd_i,
  output logic [SCR1_DBG_DMI_ARB_PORTS-1:0] gnt_o
);

  // ptr_q names the port preferred when both request.
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt_o = req_i;
    if (&req_i) begin
      gnt_o = port_onehot(ptr_q);
    end
  end

  // After a grant the other port becomes preferred.
  assign ptr_d = (upd_i && (|gnt_o)) ? ~gnt_o[1] : ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/scr1_dmi_arb.sv
// Two-port arbiter/sequencer in front of the Debug Module DMI slave.
// Port 0 is the JTAG DTM, port 1 the system-side debug access port.
// One access is in flight at a time; dm_req is held until dm_resp or
// until the timeout aborts the access with rq_err = 1.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   rq_req/wr/addr/wdata - per-port request (port i at [i*W +: W])
//   rq_ack               - one-hot accept pulse (same cycle as grant)
//   rq_resp              - one-hot completion pulse
//   rq_err, rq_rdata     - completion status / read data, held between pulses
//   dm_req/wr/addr/wdata - DMI request to the DM, registered
//   dm_resp, dm_rdata    - DM response and read data
module scr1_dmi_arb
  import scr1_dmi_arb_pkg::*;
#(
  parameter int ADDR_W  = SCR1_DBG_DMI_ADDR_WIDTH,
  parameter int DATA_W  = SCR1_DBG_DMI_DATA_WIDTH,
  parameter int TMO_CYC = SCR1_DBG_DMI_ARB_TMO_CYC
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [SCR1_DBG_DMI_ARB_PORTS-1:0]        rq_req,
  input  logic [SCR1_DBG_DMI_ARB_PORTS-1:0]        rq_wr,
  input  logic [SCR1_DBG_DMI_ARB_PORTS*ADDR_W-1:0] rq_addr,
  input  logic [SCR1_DBG_DMI_ARB_PORTS*DATA_W-1:0] rq_wdata,
  output logic [SCR1_DBG_DMI_ARB_PORTS-1:0]        rq_ack,
  output logic [SCR1_DBG_DMI_ARB_PORTS-1:0]        rq_resp,
  output logic                                     rq_err,
  output logic [DATA_W-1:0]                        rq_rdata,
  output logic                                     dm_req,
  output logic                                     dm_wr,
  output logic [ADDR_W-1:0]                        dm_addr,
  output logic [DATA_W-1:0]                        dm_wdata,
  input  logic                                     dm_resp,
  input  logic [DATA_W-1:0]                        dm_rdata
);

  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

  type_scr1_dmi_arb_fsm_e state_q, state_d;
  logic                   owner_q, owner_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   cmd_wr_q, cmd_wr_d;
  logic [ADDR_W-1:0]      cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]      cmd_wdata_q, cmd_wdata_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic [SCR1_DBG_DMI_ARB_PORTS-1:0] gnt;
  logic [SCR1_DBG_DMI_ARB_PORTS-1:0] ack_c;
  logic                              rr_upd;

  // Requests are only looked at in IDLE, so the arbiter sees nothing otherwise.
  scr1_dmi_arb_rr u_rr (
    .clk   (clk),
    .rst   (rst),
    .req_i (rq_req & {SCR1_DBG_DMI_ARB_PORTS{state_q == IDLE}}),
    .upd_i (rr_upd),
    .gnt_o (gnt)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    ack_c       = '0;
    rr_upd      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          ack_c       = gnt;
          rr_upd      = 1'b1;
          owner_d     = gnt[1];
          cmd_wr_d    = gnt[1] ? rq_wr[1] : rq_wr[0];
          cmd_addr_d  = gnt[1] ? rq_addr[ADDR_W +: ADDR_W] : rq_addr[0 +: ADDR_W];
          cmd_wdata_d = gnt[1] ? rq_wdata[DATA_W +: DATA_W] : rq_wdata[0 +: DATA_W];
          cnt_d       = '0;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 16'd1;
        // A response in the last timeout cycle still counts as success.
        if (dm_resp) begin
          rdata_d = cmd_wr_q ? '0 : dm_rdata;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == TMO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Grant decision is combinational; keep it quiet while reset is applied.
  assign rq_ack   = ack_c & {SCR1_DBG_DMI_ARB_PORTS{~rst}};
  assign rq_resp  = (state_q == DONE) ? port_onehot(owner_q) : '0;
  assign rq_err   = err_q;
  assign rq_rdata = rdata_q;
  assign dm_req   = (state_q == ACCESS);
  assign dm_wr    = cmd_wr_q;
  assign dm_addr  = cmd_addr_q;
  assign dm_wdata = cmd_wdata_q;

endmodule

// File: tb/tb_scr1_dmi_arb.sv
module tb_scr1_dmi_arb;

  localparam int AW = 7;
  localparam int DW = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     rq_req;
  logic [1:0]     rq_wr;
  logic [2*AW-1:0] rq_addr;
  logic [2*DW-1:0] rq_wdata;
  logic [1:0]     rq_ack;
  logic [1:0]     rq_resp;
  logic           rq_err;
  logic [DW-1:0]  rq_rdata;
  logic           dm_req;
  logic           dm_wr;
  logic [AW-1:0]  dm_addr;
  logic [DW-1:0]  dm_wdata;
  logic           dm_resp;
  logic [DW-1:0]  dm_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scr1_dmi_arb #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .rq_req   (rq_req),
    .rq_wr    (rq_wr),
    .rq_addr  (rq_addr),
    .rq_wdata (rq_wdata),
    .rq_ack   (rq_ack),
    .rq_resp  (rq_resp),
    .rq_err   (rq_err),
    .rq_rdata (rq_rdata),
    .dm_req   (dm_req),
    .dm_wr    (dm_wr),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_resp  (dm_resp),
    .dm_rdata (dm_rdata)
  );

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rq_req = '0; rq_wr = '0; rq_addr = '0; rq_wdata = '0;
    dm_resp = 1'b0; dm_rdata = '0;
    nxt(); nxt(); settle();
    checks++;
    if ({rq_ack, rq_resp, rq_err, dm_req, dm_wr} !== 7'b0 || rq_rdata !== 32'h0 ||
        dm_addr !== 7'h0 || dm_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs ack=%b resp=%b err=%b rdata=%h dm_req=%b dm_addr=%h exp all zero",
               rq_ack, rq_resp, rq_err, rq_rdata, dm_req, dm_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [1:0]    exp_g;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    nxt();
    rq_req = 2'b11; rq_wr = 2'b11;
    rq_addr = {7'h04, 7'h10}; rq_wdata = {32'd2, 32'd1};
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (k % 2 == 0) ? 7'h10 : 7'h04;
      exp_d = (k % 2 == 0) ? 32'd1 : 32'd2;
      settle();
      checks++;
      if (rq_ack !== exp_g) begin
        failures++; $display("FAIL b2b_ack[%0d] got=%b exp=%b", k, rq_ack, exp_g);
      end
      nxt(); settle();
      checks++;
      if (dm_req !== 1'b1 || dm_wr !== 1'b1 || dm_addr !== exp_a || dm_wdata !== exp_d) begin
        failures++;
        $display("FAIL b2b_dm[%0d] req=%b wr=%b addr=%h wdata=%h exp 1 1 %h %h",
                 k, dm_req, dm_wr, dm_addr, dm_wdata, exp_a, exp_d);
      end
      nxt();
      nxt(); dm_resp = 1'b1;
      nxt(); dm_resp = 1'b0;
      if (k == 3) rq_req = 2'b00;
      settle();
      checks++;
      if (rq_resp !== exp_g || rq_err !== 1'b0 || rq_rdata !== 32'h0) begin
        failures++;
        $display("FAIL b2b_resp[%0d] resp=%b err=%b rdata=%h exp %b 0 0", k, rq_resp, rq_err, rq_rdata, exp_g);
      end
      nxt();
    end
  endtask

  task automatic test_read_p0();
    rq_req = 2'b01; rq_wr = 2'b00; rq_addr = {7'h00, 7'h11}; rq_wdata = '0;
    settle();
    checks++;
    if (rq_ack !== 2'b01) begin failures++; $display("FAIL rd_ack got=%b exp=01", rq_ack); end
    nxt(); rq_req = 2'b00; dm_resp = 1'b1; dm_rdata = 32'hDEADBEEF; settle();
    checks++;
    if (dm_req !== 1'b1 || dm_addr !== 7'h11 || dm_wr !== 1'b0) begin
      failures++; $display("FAIL rd_dm req=%b addr=%h wr=%b exp 1 11 0", dm_req, dm_addr, dm_wr);
    end
    nxt(); dm_resp = 1'b0; dm_rdata = '0; settle();
    checks++;
    if (rq_resp !== 2'b01 || rq_rdata !== 32'hDEADBEEF || rq_err !== 1'b0 || dm_req !== 1'b0) begin
      failures++;
      $display("FAIL rd_resp resp=%b rdata=%h err=%b dm_req=%b exp 01 deadbeef 0 0", rq_resp, rq_rdata, rq_err, dm_req);
    end
    nxt(); settle();
    checks++;
    if (rq_resp !== 2'b00 || rq_rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL rd_hold resp=%b rdata=%h exp 00 deadbeef", rq_resp, rq_rdata);
    end
  endtask

  task automatic test_timeout();
    int hi;
    rq_req = 2'b10; rq_wr = 2'b00; rq_addr = {7'h2A, 7'h00}; settle();
    checks++;
    if (rq_ack !== 2'b10) begin failures++; $display("FAIL tmo_ack got=%b exp=10", rq_ack); end
    hi = 0;
    nxt(); rq_req = 2'b00; settle();
    for (int c = 0; c < 4; c++) begin
      if (dm_req === 1'b1 && rq_resp === 2'b00) hi++;
      nxt(); settle();
    end
    checks++;
    if (hi !== 4 || dm_req !== 1'b0) begin
      failures++; $display("FAIL tmo_len dm_req_cycles=%0d dm_req_after=%b exp 4 0", hi, dm_req);
    end
    checks++;
    if (rq_resp !== 2'b10 || rq_err !== 1'b1 || rq_rdata !== 32'h0) begin
      failures++; $display("FAIL tmo_resp resp=%b err=%b rdata=%h exp 10 1 0", rq_resp, rq_err, rq_rdata);
    end
    nxt();
    // Following request served normally.
    rq_req = 2'b01; rq_wr = 2'b00; rq_addr = {7'h00, 7'h05}; settle();
    checks++;
    if (rq_ack !== 2'b01) begin failures++; $display("FAIL tmo_next_ack got=%b exp=01", rq_ack); end
    nxt(); rq_req = 2'b00; dm_resp = 1'b1; dm_rdata = 32'h0000_0055;
    nxt(); dm_resp = 1'b0; dm_rdata = '0; settle();
    checks++;
    if (rq_resp !== 2'b01 || rq_err !== 1'b0 || rq_rdata !== 32'h55) begin
      failures++; $display("FAIL tmo_next_resp resp=%b err=%b rdata=%h exp 01 0 55", rq_resp, rq_err, rq_rdata);
    end
    nxt();
  endtask

  task automatic test_resp_last_cycle();
    rq_req = 2'b01; rq_wr = 2'b00; rq_addr = {7'h00, 7'h33};
    nxt(); rq_req = 2'b00;
    nxt(); nxt(); nxt(); settle();
    checks++;
    if (dm_req !== 1'b1 || rq_resp !== 2'b00) begin
      failures++; $display("FAIL last_pre dm_req=%b resp=%b exp 1 00", dm_req, rq_resp);
    end
    dm_resp = 1'b1; dm_rdata = 32'hCAFEF00D;
    nxt(); dm_resp = 1'b0; dm_rdata = '0; settle();
    checks++;
    if (rq_resp !== 2'b01 || rq_err !== 1'b0 || rq_rdata !== 32'hCAFEF00D) begin
      failures++; $display("FAIL last_resp resp=%b err=%b rdata=%h exp 01 0 cafef00d", rq_resp, rq_err, rq_rdata);
    end
    nxt();
  endtask

  task automatic test_reset_mid();
    int seen;
    rq_req = 2'b01; rq_wr = 2'b01; rq_addr = {7'h00, 7'h44}; rq_wdata = {32'h0, 32'hA5A5A5A5};
    nxt(); rq_req = 2'b00; settle();
    checks++;
    if (dm_req !== 1'b1) begin failures++; $display("FAIL mid_dmreq got=%b exp=1", dm_req); end
    nxt(); rst = 1'b1;
    nxt(); rst = 1'b0; settle();
    checks++;
    if ({rq_ack, rq_resp, rq_err, dm_req, dm_wr} !== 7'b0 || rq_rdata !== 32'h0 ||
        dm_addr !== 7'h0 || dm_wdata !== 32'h0) begin
      failures++;
      $display("FAIL mid_zero ack=%b resp=%b err=%b rdata=%h dm_req=%b addr=%h wdata=%h exp all zero",
               rq_ack, rq_resp, rq_err, rq_rdata, dm_req, dm_addr, dm_wdata);
    end
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      nxt(); settle();
      if (rq_resp !== 2'b00) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL mid_noresp resp_cycles=%0d exp 0", seen); end
    rq_req = 2'b11; rq_wr = 2'b00; rq_addr = {7'h01, 7'h02}; settle();
    checks++;
    if (rq_ack !== 2'b01) begin failures++; $display("FAIL mid_ptr ack=%b exp=01", rq_ack); end
    nxt(); rq_req = 2'b00; dm_resp = 1'b1;
    nxt(); dm_resp = 1'b0;
    nxt();
  endtask

  task automatic test_stray_resp();
    dm_resp = 1'b1; dm_rdata = 32'h1111_1111;
    nxt(); dm_resp = 1'b0; dm_rdata = '0; settle();
    checks++;
    if (rq_resp !== 2'b00 || dm_req !== 1'b0) begin
      failures++; $display("FAIL stray resp=%b dm_req=%b exp 00 0", rq_resp, dm_req);
    end
    nxt();
    rq_req = 2'b01; rq_wr = 2'b01; rq_addr = {7'h00, 7'h22}; rq_wdata = {32'h0, 32'h12345678};
    settle();
    checks++;
    if (rq_ack !== 2'b01) begin failures++; $display("FAIL wr_ack got=%b exp=01", rq_ack); end
    nxt(); rq_req = 2'b00; dm_resp = 1'b1; dm_rdata = 32'hFFFFFFFF; settle();
    checks++;
    if (dm_wr !== 1'b1 || dm_addr !== 7'h22 || dm_wdata !== 32'h12345678) begin
      failures++; $display("FAIL wr_dm wr=%b addr=%h wdata=%h exp 1 22 12345678", dm_wr, dm_addr, dm_wdata);
    end
    nxt(); dm_resp = 1'b0; dm_rdata = '0; settle();
    checks++;
    if (rq_resp !== 2'b01 || rq_err !== 1'b0 || rq_rdata !== 32'h0) begin
      failures++; $display("FAIL wr_resp resp=%b err=%b rdata=%h exp 01 0 0", rq_resp, rq_err, rq_rdata);
    end
    nxt();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_read_p0();
    test_timeout();
    test_resp_last_cycle();
    test_reset_mid();
    test_stray_resp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
